// File: rtl/rect_scan_gen_pkg.sv
// rect_scan_gen_pkg: shared state encoding, mode values and default geometry for the rectangle scanner
package rect_scan_gen_pkg;
  localparam int DEF_X_W = 9;
  localparam int DEF_Y_W = 8;
  localparam int DEF_SIZE_W = 7;
  localparam int DEF_COL_W = 3;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;
endpackage

// File: rtl/rect_scan_gen_if.sv
// rect_scan_gen_if: request/geometry inputs and pixel stream outputs of the rectangle scanner
interface rect_scan_gen_if import rect_scan_gen_pkg::*; #(
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W,
  parameter int SIZE_W = DEF_SIZE_W,
  parameter int COL_W = DEF_COL_W
) ();
  logic start;
  logic abort;
  logic mode;
  logic [X_W-1:0] x_origin;
  logic [Y_W-1:0] y_origin;
  logic [SIZE_W-1:0] width_m1;
  logic [SIZE_W-1:0] height_m1;
  logic [COL_W-1:0] colour_in;
  logic ready;
  logic [X_W-1:0] x_out;
  logic [Y_W-1:0] y_out;
  logic [COL_W-1:0] colour_out;
  logic plot;
  logic busy;
  logic done;
  modport master (
    output start, abort, mode, x_origin, y_origin, width_m1, height_m1, colour_in, ready,
    input x_out, y_out, colour_out, plot, busy, done
  );
  modport slave (
    input start, abort, mode, x_origin, y_origin, width_m1, height_m1, colour_in, ready,
    output x_out, y_out, colour_out, plot, busy, done
  );
endinterface

// File: rtl/rect_scan_step.sv
// rect_scan_step: next scan offset, last-position flag and shape membership for the current offset
module rect_scan_step import rect_scan_gen_pkg::*; #(
  parameter int SIZE_W = DEF_SIZE_W
) (
  input  logic              mode,
  input  logic [SIZE_W-1:0] i_x,
  input  logic [SIZE_W-1:0] i_y,
  input  logic [SIZE_W-1:0] width_m1,
  input  logic [SIZE_W-1:0] height_m1,
  output logic [SIZE_W-1:0] nx,
  output logic [SIZE_W-1:0] ny,
  output logic              last,
  output logic              in_shape
);
  logic row_end, edge_row, skip_gap;
  // Row-major walk; outline interior rows hop straight from the left to the right edge
  always_comb begin
    row_end = i_x == width_m1;
    edge_row = i_y == '0 || i_y == height_m1;
    skip_gap = mode == MODE_OUTLINE && !edge_row && i_x == '0;
    nx = row_end ? '0 : skip_gap ? width_m1 : i_x + SIZE_W'(1);
    ny = row_end ? i_y + SIZE_W'(1) : i_y;
    last = row_end && i_y == height_m1;
    in_shape = mode == MODE_OUTLINE ? (edge_row || i_x == '0 || row_end) : 1'b1;
  end
endmodule

// File: rtl/rect_scan_gen.sv
// rect_scan_gen: walks a latched W x H rectangle row-major, emitting clipped pixels under backpressure
module rect_scan_gen import rect_scan_gen_pkg::*; #(
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W,
  parameter int SIZE_W = DEF_SIZE_W,
  parameter int COL_W = DEF_COL_W,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input logic           clock,
  input logic           resetn,
  rect_scan_gen_if.slave bus
);
  localparam logic [X_W:0] SW = SCREEN_W[X_W:0];
  localparam logic [Y_W:0] SH = SCREEN_H[Y_W:0];
  state_t state, state_nx;
  logic mode_q;
  logic [X_W-1:0] x_org;
  logic [Y_W-1:0] y_org;
  logic [SIZE_W-1:0] w_q, h_q, i_x, i_y, nx, ny;
  logic [COL_W-1:0] col_q;
  logic [X_W:0] sx;
  logic [Y_W:0] sy;
  logic last, in_shape, clipped, adv, accept;
  rect_scan_step #(.SIZE_W(SIZE_W)) u_step (
    .mode(mode_q), .i_x(i_x), .i_y(i_y), .width_m1(w_q), .height_m1(h_q),
    .nx(nx), .ny(ny), .last(last), .in_shape(in_shape)
  );
  assign sx = {1'b0, x_org} + (X_W+1)'(i_x);
  assign sy = {1'b0, y_org} + (Y_W+1)'(i_y);
  assign clipped = sx[X_W] || sy[Y_W] || sx >= SW || sy >= SH;
  assign adv = bus.ready || !bus.plot;
  assign accept = state == ST_IDLE && bus.start && !bus.abort;
  assign bus.x_out = sx[X_W-1:0];
  assign bus.y_out = sy[Y_W-1:0];
  assign bus.colour_out = col_q;
  // State register
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= ST_IDLE;
    else state <= state_nx;
  // Next state: abort wins in RUN, DONE always falls back to IDLE
  always_comb begin
    state_nx = state == ST_IDLE ? (accept ? ST_RUN : ST_IDLE) :
               state == ST_RUN  ? (bus.abort ? ST_IDLE : (adv && last) ? ST_DONE : ST_RUN) :
               ST_IDLE;
  end
  // Status and pixel-valid outputs
  always_comb begin
    bus.busy = state == ST_RUN;
    bus.done = state == ST_DONE;
    bus.plot = state == ST_RUN && in_shape && !clipped;
  end
  // Latch the request on accepted start and step the offsets on each advance
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      mode_q <= 1'b0;
      x_org <= '0;
      y_org <= '0;
      w_q <= '0;
      h_q <= '0;
      col_q <= '0;
      i_x <= '0;
      i_y <= '0;
    end else if (accept) begin
      mode_q <= bus.mode;
      x_org <= bus.x_origin;
      y_org <= bus.y_origin;
      w_q <= bus.width_m1;
      h_q <= bus.height_m1;
      col_q <= bus.colour_in;
      i_x <= '0;
      i_y <= '0;
    end else if (state == ST_RUN && !bus.abort && adv) begin
      i_x <= nx;
      i_y <= ny;
    end
endmodule

// File: tb/tb_rect_scan_gen.sv
// tb_rect_scan_gen: directed checks of fill/outline scans, backpressure, clipping, abort and reset
module tb_rect_scan_gen;
  import rect_scan_gen_pkg::*;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int nbusy, ndone;
  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];
  rect_scan_gen_if bus ();
  rect_scan_gen dut (.clock(clock), .resetn(resetn), .bus(bus));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  function automatic logic [16:0] pk(input int x, input int y);
    return {x[8:0], y[7:0]};
  endfunction
  task automatic launch(input logic m, input int x, input int y, input int w, input int h, input int c);
    bus.mode = m;
    bus.x_origin = x[8:0];
    bus.y_origin = y[7:0];
    bus.width_m1 = w[6:0];
    bus.height_m1 = h[6:0];
    bus.colour_in = c[2:0];
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
  endtask
  task automatic collect;
    got_q.delete();
    nbusy = 0;
    ndone = 0;
    for (int i = 0; i < 500; i++) begin
      if (bus.plot && bus.ready) got_q.push_back({bus.x_out, bus.y_out});
      if (bus.busy) nbusy++;
      if (bus.done) begin
        ndone++;
        tick;
        check("done_one_cycle", bus.done, 0);
        return;
      end
      if (!bus.busy) begin
        check("scan_end_done", bus.done, 1);
        return;
      end
      tick;
    end
    check("scan_timeout_busy", bus.busy, 0);
  endtask
  task automatic cmp_list(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_px%0d", tag, i), got_q[i], exp_q[i]);
  endtask
  initial begin
    int d;
    bus.start = 0; bus.abort = 0; bus.mode = 0; bus.ready = 1;
    bus.x_origin = 0; bus.y_origin = 0; bus.width_m1 = 0; bus.height_m1 = 0; bus.colour_in = 0;
    #2;
    check("rst_plot", bus.plot, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_x", bus.x_out, 0);
    check("rst_y", bus.y_out, 0);
    check("rst_col", bus.colour_out, 0);
    @(negedge clock) resetn = 1'b1;
    tick;
    launch(MODE_FILL, 10, 20, 2, 1, 5);
    check("fill_busy", bus.busy, 1);
    check("fill_col", bus.colour_out, 5);
    collect;
    exp_q = '{pk(10,20), pk(11,20), pk(12,20), pk(10,21), pk(11,21), pk(12,21)};
    cmp_list("fill");
    check("fill_cycles", nbusy, 6);
    check("fill_done", ndone, 1);
    launch(MODE_OUTLINE, 0, 0, 3, 3, 2);
    collect;
    exp_q.delete();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        if (x == 0 || x == 3 || y == 0 || y == 3) exp_q.push_back(pk(x, y));
    cmp_list("outline");
    check("outline_cycles", nbusy, 12);
    check("outline_done", ndone, 1);
    launch(MODE_FILL, 10, 20, 2, 0, 3);
    check("bp_x0", bus.x_out, 10);
    tick;
    bus.ready = 0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_hold_x%0d", k), bus.x_out, 11);
      check($sformatf("bp_hold_plot%0d", k), bus.plot, 1);
      if (k < 3) tick;
    end
    bus.ready = 1;
    tick;
    check("bp_x2", bus.x_out, 12);
    check("bp_x2_plot", bus.plot, 1);
    tick;
    check("bp_done", bus.done, 1);
    tick;
    launch(MODE_FILL, 158, 119, 3, 1, 7);
    collect;
    exp_q = '{pk(158,119), pk(159,119)};
    cmp_list("clip");
    check("clip_cycles", nbusy, 8);
    check("clip_done", ndone, 1);
    launch(MODE_FILL, 10, 20, 2, 1, 5);
    check("sb_x0", bus.x_out, 10);
    bus.start = 1;
    bus.x_origin = 50;
    tick;
    bus.start = 0;
    check("sb_x1", bus.x_out, 11);
    check("sb_y1", bus.y_out, 20);
    collect;
    exp_q = '{pk(11,20), pk(12,20), pk(10,21), pk(11,21), pk(12,21)};
    cmp_list("start_busy");
    check("sb_done", ndone, 1);
    launch(MODE_FILL, 10, 20, 2, 1, 5);
    tick;
    tick;
    bus.abort = 1;
    tick;
    bus.abort = 0;
    check("abort_busy", bus.busy, 0);
    check("abort_plot", bus.plot, 0);
    check("abort_done", bus.done, 0);
    d = 0;
    repeat (3) begin
      tick;
      d += int'(bus.done) + int'(bus.busy);
    end
    check("abort_quiet", d, 0);
    bus.start = 1;
    bus.abort = 1;
    tick;
    bus.start = 0;
    bus.abort = 0;
    check("abort_beats_start", bus.busy, 0);
    launch(MODE_FILL, 10, 20, 2, 1, 5);
    tick;
    check("mid_busy", bus.busy, 1);
    resetn = 0;
    #1;
    check("arst_plot", bus.plot, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_x", bus.x_out, 0);
    check("arst_y", bus.y_out, 0);
    #1 resetn = 1;
    tick;
    check("arst_idle", bus.busy, 0);
    launch(MODE_FILL, 5, 6, 0, 0, 1);
    collect;
    exp_q = '{pk(5,6)};
    cmp_list("single");
    check("single_cycles", nbusy, 1);
    check("single_done", ndone, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
